// File: rtl/imem_load_ctrl.sv
// Instruction memory port sequencer: streams a byte-serial program image into
// memory, then hands the port to the fetch stage and releases the CPU.
module imem_load_ctrl #(
    parameter int MEM_BYTES = 1025,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [63:0]      load_base,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_ready,
    input  logic [63:0]      PC,
    output logic [63:0]      mem_addr,
    output logic             mem_wEn,
    output logic [7:0]       mem_wdata,
    output logic             cpu_run,
    output logic             load_busy,
    output logic             load_err,
    output logic [CNT_W-1:0] load_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam logic [63:0]      MEM_LIMIT = 64'(MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [63:0]      load_addr_q, load_addr_d;
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic             load_err_q, load_err_d;

    always_comb begin
        state_d      = state_q;
        load_addr_d  = load_addr_q;
        load_count_d = load_count_q;
        load_err_d   = load_err_q;
        byte_ready   = 1'b0;
        mem_addr     = PC;
        mem_wEn      = 1'b0;
        mem_wdata    = 8'h00;
        cpu_run      = 1'b0;
        load_busy    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    load_addr_d  = load_base;
                    load_count_d = '0;
                end
            end

            ST_LOAD: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                mem_addr   = load_addr_q;
                if (byte_valid) begin
                    // Overflowing bytes are consumed but never written; byte_last is moot then.
                    if (load_addr_q >= MEM_LIMIT) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        mem_wEn     = 1'b1;
                        mem_wdata   = byte_data;
                        load_addr_d = load_addr_q + 64'd1;
                        if (load_count_q != CNT_MAX) begin
                            load_count_d = load_count_q + 1'b1;
                        end
                        if (byte_last) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end

            ST_RUN: begin
                cpu_run = 1'b1;
                if (load_start) begin
                    state_d      = ST_LOAD;
                    load_addr_d  = load_base;
                    load_count_d = '0;
                end
            end

            ST_ERR: begin
                if (load_start) begin
                    state_d      = ST_LOAD;
                    load_addr_d  = load_base;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            load_addr_q  <= '0;
            load_count_q <= '0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_addr_q  <= load_addr_d;
            load_count_q <= load_count_d;
            load_err_q   <= load_err_d;
        end
    end

    assign load_err   = load_err_q;
    assign load_count = load_count_q;

endmodule
